fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 65 ++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 3-stage pipeline.
// Owns the program counter, presents it to a combinational instruction
// memory, and captures the returned word with its PC into the IF/EX register.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   stall          execute cannot accept; hold PC and IF/EX
//   redirect_valid taken branch/jump resolved in execute (overrides stall)
//   redirect_pc    redirect target; bits [1:0] are ignored
//   imem_addr      byte address to instruction memory (current PC)
//   imem_instr     instruction word for imem_addr, same cycle
//   ifex_pc        PC of the instruction held in IF/EX
//   ifex_instr     instruction held in IF/EX (NOP_INSTR when not valid)
//   ifex_valid     IF/EX holds a real instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifex_pc,
  output logic [31:0] ifex_instr,
  output logic        ifex_valid
);

  logic [31:0] pc_q;
  logic [31:0] ifex_pc_q;
  logic [31:0] ifex_instr_q;
  logic        ifex_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifex_pc_q    <= '0;
      ifex_instr_q <= NOP_INSTR;
      ifex_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      // The word fetched this cycle is on the wrong path: squash it into a
      // bubble. A stalled instruction here is the branch itself, so the
      // redirect wins over stall.
      pc_q         <= {redirect_pc[31:2], 2'b00};
      ifex_pc_q    <= pc_q;
      ifex_instr_q <= NOP_INSTR;
      ifex_valid_q <= 1'b0;
    end else if (!stall) begin
      // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
      pc_q         <= pc_q + 32'd4;
      ifex_pc_q    <= pc_q;
      ifex_instr_q <= imem_instr;
      ifex_valid_q <= 1'b1;
    end
  end

  assign imem_addr  = pc_q;
  assign ifex_pc    = ifex_pc_q;
  assign ifex_instr = ifex_instr_q;
  assign ifex_valid = ifex_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan scenarios, then
// randomized stall/redirect/reset traffic, against a cycle-level model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifex_pc;
  logic [31:0] ifex_instr;
  logic        ifex_valid;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .ifex_pc       (ifex_pc),
    .ifex_instr    (ifex_instr),
    .ifex_valid    (ifex_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: 64 words, aliased over the whole address space.
  logic [31:0] mem [64];
  assign imem_instr = mem[imem_addr[7:2]];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model of the architectural state.
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifinstr;
  logic        m_ifvalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return mem[addr[7:2]];
  endfunction

  // One clock cycle with the given inputs; model advances, outputs compared.
  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rpc);
    reset          = rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    if (rst) begin
      m_pc = RESET_PC; m_ifpc = '0; m_ifinstr = NOP_INSTR; m_ifvalid = 1'b0;
    end else if (rv) begin
      m_ifpc = m_pc; m_ifinstr = NOP_INSTR; m_ifvalid = 1'b0;
      m_pc = rpc & 32'hFFFF_FFFC;
    end else if (!st) begin
      m_ifpc = m_pc; m_ifinstr = word_at(m_pc); m_ifvalid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    #1;
    chk("imem_addr",  imem_addr,  m_pc);
    chk("ifex_pc",    ifex_pc,    m_ifpc);
    chk("ifex_instr", ifex_instr, m_ifinstr);
    chk("ifex_valid", {31'd0, ifex_valid}, {31'd0, m_ifvalid});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0250_0193;
    mem[1] = 32'h0200_0513;
    mem[2] = 32'h00a1_f0b3;
    m_pc = '0; m_ifpc = '0; m_ifinstr = '0; m_ifvalid = 1'b0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    step(1, 0, 0, 0);
    chk("rst_pc",    imem_addr,  RESET_PC);
    chk("rst_instr", ifex_instr, NOP_INSTR);
    chk("rst_valid", {31'd0, ifex_valid}, 32'd0);

    // Free run
    step(0, 0, 0, 0);
    chk("run0_pc",    imem_addr,  32'h4);
    chk("run0_instr", ifex_instr, 32'h0250_0193);
    step(0, 0, 0, 0);
    chk("run1_pc",    imem_addr,  32'h8);
    chk("run1_instr", ifex_instr, 32'h0200_0513);

    // Stall 3 cycles at pc = 8
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("stall_pc",    imem_addr,  32'h8);
      chk("stall_ifpc",  ifex_pc,    32'h4);
      chk("stall_instr", ifex_instr, 32'h0200_0513);
    end
    step(0, 0, 0, 0);
    chk("unstall_ifpc",  ifex_pc,    32'h8);
    chk("unstall_instr", ifex_instr, 32'h00a1_f0b3);
    chk("unstall_pc",    imem_addr,  32'hC);

    // Advance to pc = 0x14, then redirect to 0x40
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_redir_pc", imem_addr, 32'h14);
    step(0, 0, 1, 32'h40);
    chk("redir_pc",    imem_addr,  32'h40);
    chk("redir_ifpc",  ifex_pc,    32'h14);
    chk("redir_instr", ifex_instr, NOP_INSTR);
    chk("redir_valid", {31'd0, ifex_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("target_ifpc",  ifex_pc,    32'h40);
    chk("target_instr", ifex_instr, mem[16]);
    chk("target_valid", {31'd0, ifex_valid}, 32'd1);

    // Redirect together with stall, unaligned target
    step(0, 1, 1, 32'h23);
    chk("rs_pc",    imem_addr,  32'h20);
    chk("rs_valid", {31'd0, ifex_valid}, 32'd0);
    chk("rs_instr", ifex_instr, NOP_INSTR);

    // Held redirect: bubble every cycle
    step(0, 0, 1, 32'h80);
    step(0, 0, 1, 32'h80);
    chk("held_ifpc", ifex_pc, 32'h80);
    chk("held_pc",   imem_addr, 32'h80);

    // Wrap
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_pc",   imem_addr, 32'h0);
    chk("wrap_ifpc", ifex_pc,   32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_pc2",  imem_addr, 32'h4);

    // Reset while stalled at pc = 0x18
    step(0, 0, 1, 32'h18);
    step(0, 1, 0, 0);
    chk("pre_rst_pc", imem_addr, 32'h18);
    step(1, 1, 0, 0);
    chk("mrst_pc",    imem_addr,  RESET_PC);
    chk("mrst_valid", {31'd0, ifex_valid}, 32'd0);
    chk("mrst_instr", ifex_instr, NOP_INSTR);
    chk("mrst_ifpc",  ifex_pc,    32'h0);
    step(0, 0, 0, 0);
    chk("first_valid", {31'd0, ifex_valid}, 32'd1);
    chk("first_ifpc",  ifex_pc, RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, s, v;
      logic [31:0] t;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      step(r, s, v, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
